// File: rtl/store_lane_buffer.sv
// Store lane buffer: turns byte/half/word stores into word-aligned, lane-placed writes
// and queues them in a DEPTH-entry FIFO that drains in order. Macro: STORE_ALIGN_TRAP_EN.
module store_lane_buffer #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [1:0]  req_size,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        addr_exc,
  output logic        empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  // Both ports use valid/ready: a transfer happens on a rising edge where valid and
  // ready are both high; the source holds its payload stable until that edge.

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [29:0]   r_addr_q  [DEPTH];
  logic [31:0]   r_wdata_q [DEPTH];
  logic [3:0]    r_be_q    [DEPTH];

  logic [1:0]  w_off;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic        w_trap;
  logic        w_accept;
  logic        w_push;
  logic        w_pop;

`ifdef STORE_ALIGN_TRAP_EN
  assign w_trap = ((req_size == 2'b01) & req_addr[0]) |
                  (req_size[1] & (req_addr[1:0] != 2'b00));
`else
  assign w_trap = 1'b0;
`endif

  always_comb begin
    w_off   = req_addr[1:0];
    w_be    = 4'b1111;
    w_wdata = req_data;
    case (req_size)
      2'b00: begin
        w_be    = 4'b0001 << w_off;
        w_wdata = {4{req_data[7:0]}};
      end
      2'b01: begin
`ifndef STORE_ALIGN_TRAP_EN
        w_off = {req_addr[1], 1'b0};
`endif
        w_be    = w_off[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{req_data[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = req_data;
      end
    endcase
  end

  assign req_ready = (r_count != FULL);
  assign mem_valid = (r_count != '0);
  assign empty     = (r_count == '0);
  assign w_accept  = req_valid & req_ready;
  assign w_push    = w_accept & ~w_trap;
  assign w_pop     = mem_valid & mem_ready;

  assign mem_addr  = {r_addr_q[r_rd_ptr], 2'b00};
  assign mem_wdata = r_wdata_q[r_rd_ptr];
  assign mem_be    = r_be_q[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_addr_q[i]  <= '0;
        r_wdata_q[i] <= '0;
        r_be_q[i]    <= '0;
      end
    end else begin
      if (w_push) begin
        r_addr_q[r_wr_ptr]  <= req_addr[31:2];
        r_wdata_q[r_wr_ptr] <= w_wdata;
        r_be_q[r_wr_ptr]    <= w_be;
        r_wr_ptr            <= (r_wr_ptr == LAST) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == LAST) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef STORE_ALIGN_TRAP_EN
  logic r_exc;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_exc <= 1'b0;
    else        r_exc <= w_accept & w_trap;
  end
  assign addr_exc = r_exc;
`else
  assign addr_exc = 1'b0;
`endif

endmodule

// File: tb/tb_store_lane_buffer.sv
// Directed bench for store_lane_buffer: expected writes are queued when a store is
// accepted and compared when memory takes the head entry.
module tb_store_lane_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_size;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        addr_exc;
  logic        empty;

  logic [67:0] exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  store_lane_buffer #(.DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .addr_exc(addr_exc), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference entry {addr, wdata, be}; a misaligned half keeps its a[1] lane choice.
  function automatic logic [67:0] model(input logic [31:0] a, input logic [31:0] d,
                                        input logic [1:0] s);
    logic [3:0]  be;
    logic [31:0] wd;
    case (s)
      2'b00:   begin be = 4'b0001 << a[1:0]; wd = {4{d[7:0]}}; end
      2'b01:   begin be = a[1] ? 4'b1100 : 4'b0011; wd = {2{d[15:0]}}; end
      default: begin be = 4'b1111; wd = d; end
    endcase
    return {a[31:2], 2'b00, wd, be};
  endfunction

  // Memory-side monitor: every accepted beat must match the queue head.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && mem_valid === 1'b1 && mem_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", mem_addr, 32'hFFFF_FFFF);
      end else begin
        logic [67:0] e;
        e = exp_q.pop_front();
        chk("mem_addr", mem_addr, e[67:36]);
        chk("mem_wdata", mem_wdata, e[35:4]);
        chk("mem_be", {28'd0, mem_be}, {28'd0, e[3:0]});
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                      input bit enq, output int waits);
    req_valid = 1'b1; req_addr = a; req_data = d; req_size = s;
    waits = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    chk("accept_in_time", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    if (enq) exp_q.push_back(model(a, d, s));
    #1;
  endtask

  task automatic idle();
    req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int w;
    logic [31:0] d1;
    logic [31:0] d2;
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_data = '0; req_size = '0;
    mem_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_addr_exc", {31'd0, addr_exc}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Byte store, single-cycle latency then drain
    mem_ready = 1'b1;
    send(32'h0000_1003, 32'h0000_00A5, 2'b00, 1'b1, w);
    idle();
    @(negedge clk);
    chk("sb_latency_valid", {31'd0, mem_valid}, 32'd1);
    chk("sb_empty_low", {31'd0, empty}, 32'd0);
    @(negedge clk);
    chk("sb_empty_after_pop", {31'd0, empty}, 32'd1);
    chk("sb_valid_after_pop", {31'd0, mem_valid}, 32'd0);

    // Half then word, order preserved
    @(posedge clk); #1;
    send(32'h0000_2002, 32'h1234_BEEF, 2'b01, 1'b1, w);
    send(32'h0000_2004, 32'hCAFE_F00D, 2'b10, 1'b1, w);
    idle();
    repeat (3) @(negedge clk);
    chk("sh_sw_drained", {31'd0, empty}, 32'd1);

    // Fill with memory stalled; head holds; drain on consecutive cycles
    @(posedge clk); #1;
    mem_ready = 1'b0;
    d1 = $urandom; d2 = $urandom;
    send(32'h0000_4000, d1, 2'b10, 1'b1, w);
    send(32'h0000_4004, d2, 2'b10, 1'b1, w);
    idle();
    @(negedge clk);
    chk("full_ready_low", {31'd0, req_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("hold_addr", mem_addr, 32'h0000_4000);
      chk("hold_wdata", mem_wdata, d1);
      @(negedge clk);
    end
    @(posedge clk); #1;
    mem_ready = 1'b1;
    @(negedge clk);
    chk("ready_low_during_first_pop", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    chk("ready_back_after_pop", {31'd0, req_ready}, 32'd1);
    chk("second_beat_valid", {31'd0, mem_valid}, 32'd1);
    @(negedge clk);
    chk("drain_empty", {31'd0, empty}, 32'd1);

    // Full with simultaneous pop: no bypass, accepted one cycle later
    @(posedge clk); #1;
    mem_ready = 1'b0;
    send(32'h0000_5000, $urandom, 2'b10, 1'b1, w);
    send(32'h0000_5004, $urandom, 2'b10, 1'b1, w);
    mem_ready = 1'b1;
    send(32'h0000_5008, $urandom, 2'b10, 1'b1, w);
    chk("no_full_bypass_wait", w, 32'd1);

    // Ten back-to-back stores exercising pointer wrap
    for (int i = 0; i < 10; i++) begin
      logic [1:0]  sz;
      logic [31:0] a;
      sz = 2'($urandom_range(0, 2));
      a  = 32'h0000_6000 + 32'(i * 4);
      if (sz == 2'b00) a[1:0] = 2'($urandom_range(0, 3));
      if (sz == 2'b01) a[1]   = 1'($urandom_range(0, 1));
      send(a, $urandom, sz, 1'b1, w);
      chk("b2b_no_stall", w, 32'd0);
    end
    idle();
    repeat (4) @(negedge clk);
    chk("b2b_drained", {31'd0, empty}, 32'd1);

    // Misaligned halfword
    @(posedge clk); #1;
`ifdef STORE_ALIGN_TRAP_EN
    send(32'h0000_3001, 32'h0000_ABCD, 2'b01, 1'b0, w);
    idle();
    @(negedge clk);
    chk("trap_exc_pulse", {31'd0, addr_exc}, 32'd1);
    chk("trap_not_enqueued", {31'd0, empty}, 32'd1);
    @(negedge clk);
    chk("trap_exc_one_cycle", {31'd0, addr_exc}, 32'd0);
`else
    send(32'h0000_3001, 32'h0000_ABCD, 2'b01, 1'b1, w);
    idle();
    @(negedge clk);
    chk("misaligned_exc_zero", {31'd0, addr_exc}, 32'd0);
    chk("misaligned_forced_be", {28'd0, mem_be}, 32'h3);
    @(negedge clk);
`endif

    // Asynchronous reset with two entries buffered
    @(posedge clk); #1;
    mem_ready = 1'b0;
    send(32'h0000_7000, $urandom, 2'b10, 1'b1, w);
    send(32'h0000_7004, $urandom, 2'b10, 1'b1, w);
    idle();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    chk("async_rst_empty", {31'd0, empty}, 32'd1);
    chk("async_rst_req_ready", {31'd0, req_ready}, 32'd1);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("no_stale_after_reset", {31'd0, empty}, 32'd1);
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
